// File: rtl/ser2pal_multi.sv
`default_nettype none
// ============================================================================
// Module   : ser2pal_multi
// Purpose  : 1..N lane serial-to-parallel converter with valid/ready output.
//            Per-frame even parity is enabled by defining SER2PAL_MULTI_PARITY_EN.
// Revision : 1.0
// ============================================================================
module ser2pal_multi #(
  parameter int WIDTH     = 8,
  parameter int LANES     = 1,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clka,
  input  logic             rst,
  input  logic [LANES-1:0] din,
  input  logic             wr_n,
  output logic [WIDTH-1:0] dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             ovf,
  output logic             frame_err,
  output logic             parity_err
);

  localparam int               BEATS     = WIDTH / LANES;
  localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

`ifdef SER2PAL_MULTI_PARITY_EN
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DATA = 2'd1,
    ST_PAR  = 2'd2
  } state_t;
`else
  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_DATA = 1'b1
  } state_t;
`endif

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_dout;
  logic             r_dout_vld;
  logic             r_ovf;
  logic             r_frame_err;

  logic [WIDTH-1:0] w_word;
  logic [WIDTH-1:0] w_done_word;
  logic             w_last;
  logic             w_complete;
  logic             w_load;

  // The shift register is all-zero whenever a frame starts, so inserting the
  // current beat into it yields the partial word directly.
  generate
    if (MSB_FIRST) begin : g_msb_first
      always_comb begin
        w_word = r_shreg;
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            w_word[WIDTH-1-k*LANES -: LANES] = din;
          end
        end
      end
    end else begin : g_lsb_first
      always_comb begin
        w_word = r_shreg;
        for (int k = 0; k < BEATS; k++) begin
          if (r_cnt == CNT_W'(k)) begin
            w_word[k*LANES +: LANES] = din;
          end
        end
      end
    end
  endgenerate

  assign w_last = (r_cnt == LAST_BEAT);

`ifdef SER2PAL_MULTI_PARITY_EN
  logic r_parity_err;
  logic w_par_hit;
  logic w_par_bad;

  assign w_par_hit   = !wr_n && (r_state == ST_PAR);
  assign w_par_bad   = w_par_hit && (din[0] != ^r_shreg);
  assign w_complete  = w_par_hit && (din[0] == ^r_shreg);
  assign w_done_word = r_shreg;
  assign parity_err  = r_parity_err;
`else
  assign w_complete  = !wr_n && w_last;
  assign w_done_word = w_word;
  assign parity_err  = 1'b0;
`endif

  // A finished word may replace the held one only if it leaves this same edge.
  assign w_load = w_complete && (!r_dout_vld || dout_rdy);

  always_ff @(posedge clka) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_dout       <= '0;
      r_dout_vld   <= 1'b0;
      r_ovf        <= 1'b0;
      r_frame_err  <= 1'b0;
`ifdef SER2PAL_MULTI_PARITY_EN
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_ovf        <= w_complete && r_dout_vld && !dout_rdy;
      r_frame_err  <= wr_n && (r_state != ST_IDLE);
`ifdef SER2PAL_MULTI_PARITY_EN
      r_parity_err <= w_par_bad;
`endif

      if (w_load) begin
        r_dout     <= w_done_word;
        r_dout_vld <= 1'b1;
      end else if (dout_rdy) begin
        r_dout_vld <= 1'b0;
      end

      if (wr_n) begin
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_shreg <= '0;
`ifdef SER2PAL_MULTI_PARITY_EN
      end else if (r_state == ST_PAR) begin
        // Parity beat ends the frame whether it matched or not.
        r_state <= ST_IDLE;
        r_cnt   <= '0;
        r_shreg <= '0;
`endif
      end else if (w_last) begin
        r_cnt   <= '0;
`ifdef SER2PAL_MULTI_PARITY_EN
        r_state <= ST_PAR;
        r_shreg <= w_word;
`else
        r_state <= ST_IDLE;
        r_shreg <= '0;
`endif
      end else begin
        r_cnt   <= r_cnt + CNT_W'(1);
        r_state <= ST_DATA;
        r_shreg <= w_word;
      end
    end
  end

  assign dout      = r_dout;
  assign dout_vld  = r_dout_vld;
  assign ovf       = r_ovf;
  assign frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_ser2pal_multi.sv
`default_nettype none
// ============================================================================
// Module   : tb_ser2pal_multi
// Purpose  : scoreboard bench for ser2pal_multi (8x1 MSB-first, 16x4 both orders).
// Revision : 1.0
// ============================================================================
module tb_ser2pal_multi;

  logic        clka   = 1'b0;
  logic        rst    = 1'b1;
  logic        din8   = 1'b0;
  logic        wr8_n  = 1'b1;
  logic        rdy8   = 1'b1;
  logic [3:0]  din16  = 4'h0;
  logic        wr16_n = 1'b1;
  logic        rdy16  = 1'b1;

  logic [7:0]  dout8;
  logic        vld8, ovf8, ferr8, perr8;
  logic [15:0] dout16l, dout16m;
  logic        vld16l, ovf16l, ferr16l, perr16l;
  logic        vld16m, ovf16m, ferr16m, perr16m;

  int          n_vec = 0;
  int          n_err = 0;
  logic [7:0]  exp8[$];
  logic [15:0] exp16l[$];
  logic [15:0] exp16m[$];

  always #5 clka = ~clka;

  ser2pal_multi #(.WIDTH(8), .LANES(1), .MSB_FIRST(1'b1)) u_dut8 (
    .clka(clka), .rst(rst), .din(din8), .wr_n(wr8_n),
    .dout(dout8), .dout_vld(vld8), .dout_rdy(rdy8),
    .ovf(ovf8), .frame_err(ferr8), .parity_err(perr8)
  );

  ser2pal_multi #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b0)) u_dut16l (
    .clka(clka), .rst(rst), .din(din16), .wr_n(wr16_n),
    .dout(dout16l), .dout_vld(vld16l), .dout_rdy(rdy16),
    .ovf(ovf16l), .frame_err(ferr16l), .parity_err(perr16l)
  );

  ser2pal_multi #(.WIDTH(16), .LANES(4), .MSB_FIRST(1'b1)) u_dut16m (
    .clka(clka), .rst(rst), .din(din16), .wr_n(wr16_n),
    .dout(dout16m), .dout_vld(vld16m), .dout_rdy(rdy16),
    .ovf(ovf16m), .frame_err(ferr16m), .parity_err(perr16m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_vec++;
    n_err++;
    $display("FAIL %s: got word %0h expected no word", name, act);
  endtask

  // Monitors: a transfer happens on the edge following a negedge with vld&rdy.
  always @(negedge clka) begin
    if (vld8 && rdy8) begin
      if (exp8.size() == 0) unexpected("dut8_word", 32'(dout8));
      else check("dut8_word", 32'(dout8), 32'(exp8.pop_front()));
    end
    if (vld16l && rdy16) begin
      if (exp16l.size() == 0) unexpected("dut16_lsb_word", 32'(dout16l));
      else check("dut16_lsb_word", 32'(dout16l), 32'(exp16l.pop_front()));
    end
    if (vld16m && rdy16) begin
      if (exp16m.size() == 0) unexpected("dut16_msb_word", 32'(dout16m));
      else check("dut16_msb_word", 32'(dout16m), 32'(exp16m.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clka);
    #1;
  endtask

  task automatic beat8(input logic b);
    wr8_n = 1'b0;
    din8  = b;
    tick();
  endtask

  task automatic idle8();
    wr8_n = 1'b1;
    tick();
  endtask

  task automatic send8(input logic [7:0] w, input bit expect_it);
    if (expect_it) exp8.push_back(w);
    for (int i = 7; i >= 0; i--) beat8(w[i]);
`ifdef SER2PAL_MULTI_PARITY_EN
    beat8(^w);
`endif
  endtask

  task automatic send16(input logic [3:0] b0, input logic [3:0] b1,
                        input logic [3:0] b2, input logic [3:0] b3,
                        input logic [15:0] exp_l, input logic [15:0] exp_m);
    logic [3:0] seq [4];
    seq[0] = b0; seq[1] = b1; seq[2] = b2; seq[3] = b3;
    exp16l.push_back(exp_l);
    exp16m.push_back(exp_m);
    for (int i = 0; i < 4; i++) begin
      wr16_n = 1'b0;
      din16  = seq[i];
      tick();
    end
`ifdef SER2PAL_MULTI_PARITY_EN
    din16 = {3'b000, ^{b0, b1, b2, b3}};
    tick();
`endif
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("rst_dout", 32'(dout8), 32'h0);
    check("rst_vld", 32'(vld8), 32'h0);
    check("rst_ovf", 32'(ovf8), 32'h0);
    check("rst_frame_err", 32'(ferr8), 32'h0);
    check("rst_parity_err", 32'(perr8), 32'h0);
    check("rst_dout16", 32'(dout16l), 32'h0);

    // 8'hA5, MSB first, consumer always ready
    rdy8 = 1'b1;
    send8(8'hA5, 1'b1);
    check("a5_vld_latency", 32'(vld8), 32'h1);
    check("a5_dout", 32'(dout8), 32'hA5);
    idle8();
    check("a5_vld_one_cycle", 32'(vld8), 32'h0);

    // back-to-back frames into a stalled consumer
    rdy8 = 1'b0;
    send8(8'h3C, 1'b1);
    send8(8'hC3, 1'b0);
    check("ovf_pulse", 32'(ovf8), 32'h1);
    check("ovf_hold_dout", 32'(dout8), 32'h3C);
    idle8();
    check("ovf_one_cycle", 32'(ovf8), 32'h0);
    check("b2b_no_frame_err", 32'(ferr8), 32'h0);
    check("ovf_vld_held", 32'(vld8), 32'h1);
    rdy8 = 1'b1;
    tick();
    check("rdy_clears_vld", 32'(vld8), 32'h0);

    // aborted frame after 5 beats, then a clean frame
    beat8(1'b1); beat8(1'b0); beat8(1'b1); beat8(1'b0); beat8(1'b1);
    idle8();
    check("frame_err_pulse", 32'(ferr8), 32'h1);
    check("abort_no_word", 32'(vld8), 32'h0);
    tick();
    check("frame_err_one_cycle", 32'(ferr8), 32'h0);
    send8(8'hFF, 1'b1);
    idle8();
    tick();

    // reset mid-frame
    beat8(1'b1); beat8(1'b1); beat8(1'b0);
    rst = 1'b1;
    tick();
    check("rst_mid_dout", 32'(dout8), 32'h0);
    check("rst_mid_vld", 32'(vld8), 32'h0);
    check("rst_mid_frame_err", 32'(ferr8), 32'h0);
    rst = 1'b0;
    wr8_n = 1'b1;
    tick();
    check("rst_left_idle", 32'(ferr8), 32'h0);

    // reset while a word is held
    rdy8 = 1'b0;
    send8(8'h5A, 1'b0);
    idle8();
    check("held_vld", 32'(vld8), 32'h1);
    check("held_dout", 32'(dout8), 32'h5A);
    rst = 1'b1;
    tick();
    check("rst_held_vld", 32'(vld8), 32'h0);
    check("rst_held_dout", 32'(dout8), 32'h0);
    rst = 1'b0;
    rdy8 = 1'b1;
    send8(8'h96, 1'b1);
    idle8();
    tick();

`ifdef SER2PAL_MULTI_PARITY_EN
    begin
      logic [7:0] pw;
      pw = 8'h07;
      send8(pw, 1'b1);
      idle8();
      tick();
      for (int i = 7; i >= 0; i--) beat8(pw[i]);
      beat8(1'b0);
      check("parity_err_pulse", 32'(perr8), 32'h1);
      check("parity_drop", 32'(vld8), 32'h0);
      idle8();
      check("parity_err_one_cycle", 32'(perr8), 32'h0);
    end
`endif

    // 16-bit, 4 lanes, both bit orders, back-to-back
    rdy16 = 1'b1;
    send16(4'h1, 4'h2, 4'h3, 4'h4, 16'h4321, 16'h1234);
    send16(4'hA, 4'h5, 4'h0, 4'hF, 16'hF05A, 16'hA50F);
    wr16_n = 1'b1;
    tick();
    tick();
    check("dut16_no_frame_err", 32'(ferr16l | ferr16m), 32'h0);

    tick();
    check("dut8_drained", 32'(exp8.size()), 32'h0);
    check("dut16_lsb_drained", 32'(exp16l.size()), 32'h0);
    check("dut16_msb_drained", 32'(exp16m.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
